regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised RISC-V integer register file with a built-in scoreboard for the pipelined core. It provides two combinational read ports and one synchronous write port, and hardwires x0 to zero. Per-register pending bits track in-flight destinations so the hazard unit can stall on RAW dependencies. It replaces the single-cycle register file in the decode/writeback path and keeps a debug tap on one architectural register for the testbench.

## Interface
Parameters:
- ADDRESS_WIDTH, 5, register index width; NUM_REGS = 2**ADDRESS_WIDTH
- DATA_WIDTH, 32, register width
- DBG_REG, 10, index driven onto dbg_data (a0)

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - clk, input, 1, rising-edge clock
  - rst_n, input, 1, synchronous active-low reset
- Read ports:
  - AD1, input, ADDRESS_WIDTH, read port 1 index
  - AD2, input, ADDRESS_WIDTH, read port 2 index
  - RD1, output, DATA_WIDTH, read port 1 data
  - RD2, output, DATA_WIDTH, read port 2 data
  - BUSY1, output, 1, AD1 has a pending write
  - BUSY2, output, 1, AD2 has a pending write
- Allocate (issue) port:
  - ALLOC_EN, input, 1, mark ALLOC_AD pending
  - ALLOC_AD, input, ADDRESS_WIDTH, destination being issued
- Write (writeback) port:
  - WE3, input, 1, writeback strobe
  - AD3, input, ADDRESS_WIDTH, writeback index
  - WD3, input, DATA_WIDTH, writeback data
- Status:
  - pend_cnt, output, ADDRESS_WIDTH+1, number of pending registers
  - wb_err, output, 1, sticky flag: a writeback hit a non-pending register
  - dbg_data, output, DATA_WIDTH, contents of register DBG_REG

## Operation
- Storage: NUM_REGS × DATA_WIDTH registers plus NUM_REGS pending bits.
- Register 0 behaviour:
  - Reads of index 0 return 0.
  - BUSY for index 0 is always 0.
  - Writes and allocates to index 0 are ignored; they do not affect pend_cnt or wb_err.
- Reset (rst_n=0 at a clock edge):
  - All registers and pending bits go to 0, and pend_cnt and wb_err go to 0.
  - Reset overrides simultaneous ALLOC_EN/WE3.
- Allocate: at the edge where ALLOC_EN=1, ALLOC_AD≠0 and the register is not pending, its pending bit is set and pend_cnt is incremented. Allocating an already-pending register is a no-op.
- Writeback: at the edge where WE3=1 and AD3≠0, regs[AD3] takes WD3.
  - If the register is pending, its bit is cleared and pend_cnt is decremented.
  - If the register is not pending, data is still written and wb_err is set (sticky until reset).
- Simultaneous ALLOC_EN and WE3 on the same index ≠0:
  - Data is written.
  - The pending bit ends up set, because a new producer now owns the register.
  - pend_cnt is unchanged if the bit was set before; it increments if the bit was clear, and wb_err is set in that case.
- Simultaneous ALLOC_EN and WE3 on different indices: both take effect; pend_cnt changes by the net amount (+1, 0 or −1).
- Outputs RD1/RD2/BUSY1/BUSY2 are combinational from the addresses and state (see Configuration for same-cycle bypass).
- pend_cnt never exceeds NUM_REGS−1.

## Timing
- Read latency is 0 cycles (combinational). A write becomes visible on the read ports in the cycle after the edge, unless bypass is enabled.
- Pending bits, pend_cnt and wb_err are registered and update on the edge.
- dbg_data reflects the registered value and never bypasses.
- Reset values: RD1/RD2 and dbg_data are 0 after reset for every index; BUSY1/2=0; pend_cnt=0; wb_err=0.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If WE3=1 and AD3==ADn≠0 in the same cycle, RDn=WD3.
  - BUSYn is 0 in that case, unless ALLOC_EN=1 with ALLOC_AD==ADn in the same cycle, in which case BUSYn=1.
- REGFILE_BYPASS_EN undefined:
  - RDn returns the stored value.
  - BUSYn reflects only the registered pending bit.
  - The decode stage needs one extra stall cycle on writeback collisions.

## Test plan
- Reset: write x5=0x1234, then hold rst_n=0 for one edge. Expected: RD1(AD1=5)=0, pend_cnt=0, wb_err=0, dbg_data=0.
- x0 rules: WE3=1, AD3=0, WD3=0xFFFFFFFF, then ALLOC x0. Expected: RD1(AD1=0)=0, BUSY1=0, pend_cnt=0, wb_err=0.
- Scoreboard: ALLOC x3, ALLOC x7. Expected: pend_cnt=2, BUSY1(AD1=3)=1. Then writeback x3=0xA5A5A5A5. Expected: next cycle BUSY1=0, RD1=0xA5A5A5A5, pend_cnt=1.
- Collision: with x4 pending, same cycle ALLOC x4 and WE3 x4=0x55. Expected: BUSY(4)=1, RD(4)=0x55, pend_cnt unchanged, wb_err=0.
- Spurious writeback: WE3 to x9 when not pending. Expected: data written, wb_err=1, and it stays 1 through further traffic until rst_n=0.
- Bypass: write x10=0xDEAD with AD1=10 in the same cycle. Expected: RD1=0xDEAD that cycle when REGFILE_BYPASS_EN is defined, old value (0) when it is not; dbg_data=0xDEAD only from the next cycle in both builds.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Register-file bus for regfile_sb: read ports, issue-side allocate, writeback and status.
// The master side (decode/hazard unit) drives addresses and strobes; the slave returns data and status.
interface regfile_sb_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0] AD1;
    logic [ADDRESS_WIDTH-1:0] AD2;
    logic [DATA_WIDTH-1:0]    RD1;
    logic [DATA_WIDTH-1:0]    RD2;
    logic                     BUSY1;
    logic                     BUSY2;
    logic                     ALLOC_EN;
    logic [ADDRESS_WIDTH-1:0] ALLOC_AD;
    logic                     WE3;
    logic [ADDRESS_WIDTH-1:0] AD3;
    logic [DATA_WIDTH-1:0]    WD3;
    logic [ADDRESS_WIDTH:0]   pend_cnt;
    logic                     wb_err;
    logic [DATA_WIDTH-1:0]    dbg_data;

    modport master (
        output AD1, AD2, ALLOC_EN, ALLOC_AD, WE3, AD3, WD3,
        input  RD1, RD2, BUSY1, BUSY2, pend_cnt, wb_err, dbg_data
    );

    modport slave (
        input  AD1, AD2, ALLOC_EN, ALLOC_AD, WE3, AD3, WD3,
        output RD1, RD2, BUSY1, BUSY2, pend_cnt, wb_err, dbg_data
    );
endinterface

// File: rtl/regfile_sb.sv
// RISC-V integer register file with per-register pending bits for RAW stall detection.
// Optional same-cycle writeback bypass on the read ports: define REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int DBG_REG       = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_sb_if.slave   bus
);
    localparam int NUM_REGS = 2 ** ADDRESS_WIDTH;
    localparam int CW       = ADDRESS_WIDTH + 1;
    localparam logic [ADDRESS_WIDTH-1:0] DBG_IDX = ADDRESS_WIDTH'(DBG_REG);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   pend_q, pend_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  err_q, err_d;

    logic alloc_v, wb_v, same_idx, inc, dec;

    assign alloc_v  = bus.ALLOC_EN && (bus.ALLOC_AD != '0);
    assign wb_v     = bus.WE3 && (bus.AD3 != '0);
    assign same_idx = alloc_v && wb_v && (bus.ALLOC_AD == bus.AD3);
    assign inc      = alloc_v && !pend_q[bus.ALLOC_AD];
    // A writeback colliding with a re-allocate hands the register to the new producer: no decrement.
    assign dec      = wb_v && pend_q[bus.AD3] && !same_idx;

    always_comb begin
        pend_d = pend_q;
        err_d  = err_q;
        cnt_d  = cnt_q + CW'(inc) - CW'(dec);
        if (wb_v) begin
            pend_d[bus.AD3] = 1'b0;
            if (!pend_q[bus.AD3]) err_d = 1'b1;
        end
        if (alloc_v) pend_d[bus.ALLOC_AD] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            pend_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (wb_v) regs_q[bus.AD3] <= bus.WD3;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    logic [1:0][ADDRESS_WIDTH-1:0] rd_ad;
    assign rd_ad = {bus.AD2, bus.AD1};

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [DATA_WIDTH-1:0] data;
        logic                  busy;
        always_comb begin
            data = (rd_ad[p] == '0) ? '0 : regs_q[rd_ad[p]];
            busy = pend_q[rd_ad[p]];
`ifdef REGFILE_BYPASS_EN
            // wb_v excludes x0, so the bypass never exposes WD3 on index 0.
            if (wb_v && (bus.AD3 == rd_ad[p])) begin
                data = bus.WD3;
                busy = alloc_v && (bus.ALLOC_AD == rd_ad[p]);
            end
`endif
        end
    end

    assign bus.RD1      = g_rd[0].data;
    assign bus.RD2      = g_rd[1].data;
    assign bus.BUSY1    = g_rd[0].busy;
    assign bus.BUSY2    = g_rd[1].busy;
    assign bus.pend_cnt = cnt_q;
    assign bus.wb_err   = err_q;
    assign bus.dbg_data = regs_q[DBG_IDX];
endmodule

// File: tb/tb_regfile_sb.sv
// Scenario bench for regfile_sb: expected snapshots are queued when stimulus is driven
// and popped against the DUT outputs once they are due.
module tb_regfile_sb;
    localparam bit BYP =
`ifdef REGFILE_BYPASS_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct packed {
        logic [31:0] rd1;
        logic        busy1;
        logic [31:0] rd2;
        logic        busy2;
        logic [5:0]  cnt;
        logic        err;
        logic [31:0] dbg;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    obs_t exp_q[$];
    obs_t got, want;
    int   vecs = 0;
    int   miss = 0;

    always #5 clk = ~clk;

    regfile_sb_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) bus ();
    regfile_sb #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .DBG_REG(10)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    function automatic obs_t mk(logic [31:0] r1, logic b1, logic [31:0] r2, logic b2,
                                logic [5:0] c, logic e, logic [31:0] d);
        obs_t o;
        o.rd1 = r1; o.busy1 = b1; o.rd2 = r2; o.busy2 = b2; o.cnt = c; o.err = e; o.dbg = d;
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(bus.RD1, bus.BUSY1, bus.RD2, bus.BUSY2, bus.pend_cnt, bus.wb_err, bus.dbg_data);
    endfunction

    task automatic idle();
        bus.ALLOC_EN = 1'b0; bus.ALLOC_AD = '0;
        bus.WE3 = 1'b0; bus.AD3 = '0; bus.WD3 = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int a1, input int a2);
        bus.AD1 = 5'(a1);
        bus.AD2 = 5'(a2);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle(); bus.AD1 = '0; bus.AD2 = '0;
        tick(); tick();
        rst_n = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        rd(5, 6);
        got = sample(); want = exp_q.pop_front(); vecs++;
        if (got !== want) begin miss++; $display("FAIL reset_init: got %h want %h", got, want); end
        bus.WE3 = 1'b1; bus.AD3 = 5; bus.WD3 = 32'h1234;
        exp_q.push_back(mk(32'h1234, 0, 0, 0, 0, 1, 0));
        tick(); idle(); rd(5, 6);
        got = sample(); want = exp_q.pop_front(); vecs++;
        if (got !== want) begin miss++; $display("FAIL reset_prewrite: got %h want %h", got, want); end
        rst_n = 1'b0;
        bus.ALLOC_EN = 1'b1; bus.ALLOC_AD = 5;
        bus.WE3 = 1'b1; bus.AD3 = 6; bus.WD3 = 32'h77;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tick(); rst_n = 1'b1; idle(); rd(5, 6);
        got = sample(); want = exp_q.pop_front(); vecs++;
        if (got !== want) begin miss++; $display("FAIL reset_override: got %h want %h", got, want); end
    endtask

    task automatic test_x0();
        bus.WE3 = 1'b1; bus.AD3 = 0; bus.WD3 = 32'hFFFF_FFFF;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        rd(0, 0);
        got = sample(); want = exp_q.pop_front(); vecs++;
        if (got !== want) begin miss++; $display("FAIL x0_same_cycle: got %h want %h", got, want); end
        tick(); idle();
        bus.ALLOC_EN = 1'b1; bus.ALLOC_AD = 0;
        tick(); idle();
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        rd(0, 0);
        got = sample(); want = exp_q.pop_front(); vecs++;
        if (got !== want) begin miss++; $display("FAIL x0_after: got %h want %h", got, want); end
    endtask

    task automatic test_scoreboard();
        bus.ALLOC_EN = 1'b1; bus.ALLOC_AD = 3; tick();
        bus.ALLOC_AD = 7; tick(); idle();
        exp_q.push_back(mk(0, 1, 0, 1, 2, 0, 0));
        rd(3, 7);
        got = sample(); want = exp_q.pop_front(); vecs++;
        if (got !== want) begin miss++; $display("FAIL sb_alloc: got %h want %h", got, want); end
        bus.WE3 = 1'b1; bus.AD3 = 3; bus.WD3 = 32'hA5A5_A5A5;
        exp_q.push_back(mk(BYP ? 32'hA5A5_A5A5 : 32'h0, !BYP, 0, 1, 2, 0, 0));
        rd(3, 7);
        got = sample(); want = exp_q.pop_front(); vecs++;
        if (got !== want) begin miss++; $display("FAIL sb_wb_same_cycle: got %h want %h", got, want); end
        exp_q.push_back(mk(32'hA5A5_A5A5, 0, 0, 1, 1, 0, 0));
        tick(); idle(); rd(3, 7);
        got = sample(); want = exp_q.pop_front(); vecs++;
        if (got !== want) begin miss++; $display("FAIL sb_wb_next: got %h want %h", got, want); end
    endtask

    task automatic test_collision();
        bus.ALLOC_EN = 1'b1; bus.ALLOC_AD = 4; tick(); idle();
        exp_q.push_back(mk(0, 1, 0, 1, 2, 0, 0));
        rd(4, 7);
        got = sample(); want = exp_q.pop_front(); vecs++;
        if (got !== want) begin miss++; $display("FAIL col_pending: got %h want %h", got, want); end
        bus.ALLOC_EN = 1'b1; bus.ALLOC_AD = 4;
        bus.WE3 = 1'b1; bus.AD3 = 4; bus.WD3 = 32'h55;
        exp_q.push_back(mk(BYP ? 32'h55 : 32'h0, 1, 0, 1, 2, 0, 0));
        rd(4, 7);
        got = sample(); want = exp_q.pop_front(); vecs++;
        if (got !== want) begin miss++; $display("FAIL col_same_cycle: got %h want %h", got, want); end
        exp_q.push_back(mk(32'h55, 1, 0, 1, 2, 0, 0));
        tick(); idle(); rd(4, 7);
        got = sample(); want = exp_q.pop_front(); vecs++;
        if (got !== want) begin miss++; $display("FAIL col_after: got %h want %h", got, want); end
        bus.ALLOC_EN = 1'b1; bus.ALLOC_AD = 8;
        bus.WE3 = 1'b1; bus.AD3 = 7; bus.WD3 = 32'h77;
        exp_q.push_back(mk(0, 1, 32'h77, 0, 2, 0, 0));
        tick(); idle(); rd(8, 7);
        got = sample(); want = exp_q.pop_front(); vecs++;
        if (got !== want) begin miss++; $display("FAIL col_diff_idx: got %h want %h", got, want); end
    endtask

    task automatic test_spurious();
        bus.WE3 = 1'b1; bus.AD3 = 9; bus.WD3 = 32'h99;
        exp_q.push_back(mk(32'h99, 0, 32'h55, 1, 2, 1, 0));
        tick(); idle(); rd(9, 4);
        got = sample(); want = exp_q.pop_front(); vecs++;
        if (got !== want) begin miss++; $display("FAIL spur_set: got %h want %h", got, want); end
        bus.WE3 = 1'b1; bus.AD3 = 4; bus.WD3 = 32'h44;
        bus.ALLOC_EN = 1'b1; bus.ALLOC_AD = 11;
        exp_q.push_back(mk(32'h44, 0, 0, 1, 2, 1, 0));
        tick(); idle(); rd(4, 11);
        got = sample(); want = exp_q.pop_front(); vecs++;
        if (got !== want) begin miss++; $display("FAIL spur_sticky: got %h want %h", got, want); end
        bus.WE3 = 1'b1; bus.AD3 = 12; bus.WD3 = 32'hC;
        bus.ALLOC_EN = 1'b1; bus.ALLOC_AD = 12;
        exp_q.push_back(mk(32'hC, 1, 32'h99, 0, 3, 1, 0));
        tick(); idle(); rd(12, 9);
        got = sample(); want = exp_q.pop_front(); vecs++;
        if (got !== want) begin miss++; $display("FAIL spur_col_clear: got %h want %h", got, want); end
        rst_n = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tick(); rst_n = 1'b1; rd(9, 12);
        got = sample(); want = exp_q.pop_front(); vecs++;
        if (got !== want) begin miss++; $display("FAIL spur_reset: got %h want %h", got, want); end
    endtask

    task automatic test_bypass();
        bus.WE3 = 1'b1; bus.AD3 = 10; bus.WD3 = 32'hDEAD;
        exp_q.push_back(mk(BYP ? 32'hDEAD : 32'h0, 0, 0, 0, 0, 0, 0));
        rd(10, 0);
        got = sample(); want = exp_q.pop_front(); vecs++;
        if (got !== want) begin miss++; $display("FAIL byp_same_cycle: got %h want %h", got, want); end
        exp_q.push_back(mk(32'hDEAD, 0, 0, 0, 0, 1, 32'hDEAD));
        tick(); idle(); rd(10, 0);
        got = sample(); want = exp_q.pop_front(); vecs++;
        if (got !== want) begin miss++; $display("FAIL byp_next: got %h want %h", got, want); end
    endtask

    task automatic test_fill();
        for (int i = 1; i < 32; i++) begin
            bus.ALLOC_EN = 1'b1; bus.ALLOC_AD = 5'(i); tick();
        end
        bus.ALLOC_AD = 5; tick();
        bus.ALLOC_AD = 0; tick(); idle();
        exp_q.push_back(mk(0, 1, 32'hDEAD, 1, 31, 1, 32'hDEAD));
        rd(31, 10);
        got = sample(); want = exp_q.pop_front(); vecs++;
        if (got !== want) begin miss++; $display("FAIL fill_max: got %h want %h", got, want); end
        for (int i = 1; i < 32; i++) begin
            bus.WE3 = 1'b1; bus.AD3 = 5'(i); bus.WD3 = 32'(i); tick();
        end
        idle();
        exp_q.push_back(mk(32'd31, 0, 32'hA, 0, 0, 1, 32'hA));
        rd(31, 10);
        got = sample(); want = exp_q.pop_front(); vecs++;
        if (got !== want) begin miss++; $display("FAIL fill_drain: got %h want %h", got, want); end
    endtask

    initial begin
        test_reset();
        test_x0();
        test_scoreboard();
        test_collision();
        test_spurious();
        test_bypass();
        test_fill();
        if (exp_q.size() != 0) begin
            miss++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
